sm_addsub_serial: RTL and testbench
===================================

Name: sm_addsub_serial

Overview:
Multi-cycle sign-magnitude add/subtract unit for the ALU submodule set, replacing the single-cycle 8-bit adder with a parametrised, serial datapath. Operands and result use sign-magnitude format: bit M-1 is the sign, bits M-2:0 are the magnitude. The unit processes STEP_W magnitude bits per clock and uses a valid/ready handshake on both input and output. Status encoding is shared with the other ALU submodules.

Parameters:
M, 8, operand/result width incl. sign bit; M >= 3
STEP_W, 1, magnitude bits processed per clock; (M-1) % STEP_W == 0 required
(derived) N = (M-1)/STEP_W, number of CALC cycles per pass

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_valid  input  1  operand request valid
o_ready  output  1  unit idle, can accept operands
i_op  input  1  0 = A+B, 1 = A-B
i_arg_A  input  M  operand A, sign-magnitude
i_arg_B  input  M  operand B, sign-magnitude
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_result  output  M  result, sign-magnitude
o_status  output  4  [3] error, [2] negative, [1] zero, [0] overflow

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE, o_ready=1, o_valid=0, o_result=0, o_status=0, internal shift regs cleared. Reset at any time (incl. mid CALC/FIX/DONE) aborts the operation; the next edge with i_rst_n=1 may accept.
- Effective B sign sB' = B[M-1] ^ i_op. Same signs -> magnitude add; differing -> magnitude subtract |A|-|B|.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: o_ready=1. At an edge with i_valid=1, latch magnitudes, sign A, sB' and path select; clear carry/borrow; go to CALC. i_valid=0 -> stay.
- CALC: o_ready=0. Each cycle, process the STEP_W LSBs of the shift regs (add with carry or subtract with borrow), shifting the result in MSB-first. After exactly N CALC cycles:
  - Add path, final carry=1: overflow. Go to DONE with result 0, status 4'b1001.
  - Add path, no carry: sign = sign A. Go to DONE.
  - Sub path, final borrow=0: sign = sign A. Go to DONE.
  - Sub path, final borrow=1: go to FIX.
- FIX: N cycles serially computing 0 - diff (two's-complement negation of the magnitude). Sign = sB'. Then go to DONE.
- Zero rule: a result magnitude of 0 always has sign 0, status 4'b0010. Negative zero is never output, and -0 inputs behave as +0.
- Non-overflow status: [2] = result sign, [1] = result magnitude zero, [0] = 0, [3] = 0.
- DONE: o_valid=1; o_result and o_status are registered and held stable until an edge with i_ready=1, which returns the FSM to IDLE with o_valid=0. i_valid is ignored while o_ready=0.
- Latency (accept edge to o_valid high): N edges without FIX, 2N edges with FIX. Max throughput is one op per N+2 cycles (no FIX). No overlap between operations.
- o_result and o_status outside DONE hold their last value (0 after reset). Only o_valid qualifies them.

Test Plan:
- M=8, STEP_W=1: A=0x05, B=0x03, op=0, i_ready=1 -> o_valid 7 edges after accept, o_result=0x08, o_status=4'b0000.
- A=0x03, B=0x05, op=1 -> borrow, so the FIX path is taken; o_valid 14 edges after accept, o_result=0x82, o_status=4'b0100.
- A=0x7F, B=0x01, op=0 -> o_result=0x00, o_status=4'b1001; also A=0xFF, B=0x81, op=0 -> same overflow response.
- A=0x85, B=0x05, op=0 -> o_result=0x00, o_status=4'b0010 (no negative zero); A=0x80, B=0x80, op=1 -> 0x00, 4'b0010.
- Backpressure: hold i_ready=0 for 5 cycles in DONE with i_valid=1 and new operands -> o_valid, o_result and o_status stable, o_ready=0, new operands not latched; i_ready=1 -> IDLE, then the next operands are accepted.
- Reset mid-operation: assert i_rst_n=0 on the 3rd CALC cycle -> next edge o_valid=0, o_ready=1, o_result=0, o_status=0. Then A=0x0A, B=0x84, op=1 gives 0x0E, 4'b0000. Repeat with STEP_W=7 and check N=1 latency.

Source files
------------

// File: rtl/sm_addsub_serial.sv
`timescale 1ns/1ps
// sm_addsub_serial: multi-cycle sign-magnitude add/subtract.
// The magnitudes are handled STEP_W bits per clock, LSB chunk first. Each
// result chunk enters the result shift register at the top, so after N steps
// the first chunk sits at the LSB end.
// A subtract that borrows out is corrected by a second serial pass, FIX,
// which computes 0 - diff on the same subtractor.
// Status bits: [3] error, [2] negative, [1] zero, [0] overflow.
// Legal parameters: M >= 3 and (M-1) divisible by STEP_W.
module sm_addsub_serial #(
  parameter int M      = 8,
  parameter int STEP_W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_op,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  localparam int MW = M - 1;
  localparam int N  = MW / STEP_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_reg;
  logic [MW-1:0] a_reg;
  logic [MW-1:0] b_reg;
  logic [MW-1:0] res_reg;
  logic          cy_reg;
  logic [CW-1:0] cnt_reg;
  logic          sign_a_reg;
  logic          sign_b_reg;
  logic          sub_reg;
  logic [M-1:0]  result_reg;
  logic [3:0]    status_reg;

  logic [STEP_W-1:0]    a_lo;
  logic [STEP_W-1:0]    b_lo;
  logic [STEP_W:0]      step_w;
  logic                 step_cy;
  logic                 use_sub;
  logic                 last_step;
  logic [MW+STEP_W-1:0] res_cat;
  logic [MW-1:0]        res_next;
  logic [MW-1:0]        a_next;
  logic [MW-1:0]        b_next;
  logic                 fin_sign;
  logic                 mag_zero;
  logic [M-1:0]         fin_result;
  logic [3:0]           fin_status;

  // One serial step: add or subtract the low chunk of the operands, plus
  // the final result packing (sign choice and the no-negative-zero rule).
  always_comb begin
    a_lo      = a_reg[STEP_W-1:0];
    b_lo      = b_reg[STEP_W-1:0];
    use_sub   = sub_reg | (state_reg == S_FIX);
    if (use_sub) begin
      step_w = {1'b0, a_lo} - {1'b0, b_lo} - {{STEP_W{1'b0}}, cy_reg};
    end else begin
      step_w = {1'b0, a_lo} + {1'b0, b_lo} + {{STEP_W{1'b0}}, cy_reg};
    end
    // Top bit is the carry when adding and the borrow when subtracting.
    step_cy   = step_w[STEP_W];
    res_cat   = {step_w[STEP_W-1:0], res_reg};
    res_next  = res_cat[MW+STEP_W-1:STEP_W];
    a_next    = a_reg >> STEP_W;
    b_next    = b_reg >> STEP_W;
    last_step = (cnt_reg == LAST);
    // A negated difference takes the effective sign of B.
    fin_sign  = (state_reg == S_FIX) ? sign_b_reg : sign_a_reg;
    mag_zero  = (res_next == '0);
    if (mag_zero) begin
      fin_result = '0;
      fin_status = 4'b0010;
    end else begin
      fin_result = {fin_sign, res_next};
      fin_status = {1'b0, fin_sign, 2'b00};
    end
  end

  // Control FSM, serial datapath and registered result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      cy_reg     <= 1'b0;
      cnt_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      sub_reg    <= 1'b0;
      result_reg <= '0;
      status_reg <= 4'b0000;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_valid) begin
            a_reg      <= i_arg_A[MW-1:0];
            b_reg      <= i_arg_B[MW-1:0];
            res_reg    <= '0;
            cy_reg     <= 1'b0;
            cnt_reg    <= '0;
            sign_a_reg <= i_arg_A[M-1];
            sign_b_reg <= i_arg_B[M-1] ^ i_op;
            // Differing effective signs select the magnitude subtract.
            sub_reg    <= i_arg_A[M-1] ^ i_arg_B[M-1] ^ i_op;
            state_reg  <= S_CALC;
          end
        end
        S_CALC: begin
          a_reg   <= a_next;
          b_reg   <= b_next;
          res_reg <= res_next;
          cy_reg  <= step_cy;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_step) begin
            cnt_reg <= '0;
            if (!sub_reg && step_cy) begin
              result_reg <= '0;
              status_reg <= 4'b1001;
              state_reg  <= S_DONE;
            end else if (sub_reg && step_cy) begin
              // |A| < |B|: the difference is a two's-complement
              // magnitude, so negate it in a second pass (0 - diff).
              a_reg     <= '0;
              b_reg     <= res_next;
              res_reg   <= '0;
              cy_reg    <= 1'b0;
              state_reg <= S_FIX;
            end else begin
              result_reg <= fin_result;
              status_reg <= fin_status;
              state_reg  <= S_DONE;
            end
          end
        end
        S_FIX: begin
          a_reg   <= a_next;
          b_reg   <= b_next;
          res_reg <= res_next;
          cy_reg  <= step_cy;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_step) begin
            cnt_reg    <= '0;
            result_reg <= fin_result;
            status_reg <= fin_status;
            state_reg  <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (state_reg == S_IDLE);
  assign o_valid  = (state_reg == S_DONE);
  assign o_result = result_reg;
  assign o_status = status_reg;

endmodule

// File: tb/tb_sm_addsub_serial.sv
`timescale 1ns/1ps
// Directed bench for sm_addsub_serial. It uses one instance with
// STEP_W=1 (N=7) and one with STEP_W=7 (N=1), both with M=8.
module tb_sm_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v1_in, r1_out, op1, v1_out, r1_in;
  logic [7:0] a1, b1, res1;
  logic [3:0] st1;

  logic       v7_in, r7_out, op7, v7_out, r7_in;
  logic [7:0] a7, b7, res7;
  logic [3:0] st7;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  sm_addsub_serial #(.M(8), .STEP_W(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1_in), .o_ready(r1_out),
    .i_op(op1), .i_arg_A(a1), .i_arg_B(b1), .o_valid(v1_out),
    .i_ready(r1_in), .o_result(res1), .o_status(st1)
  );

  sm_addsub_serial #(.M(8), .STEP_W(7)) dut7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v7_in), .o_ready(r7_out),
    .i_op(op7), .i_arg_A(a7), .i_arg_B(b7), .o_valid(v7_out),
    .i_ready(r7_in), .o_result(res7), .o_status(st7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get(input bit sel, output logic ov, output logic orr,
                     output logic [7:0] r, output logic [3:0] s);
    if (sel) begin
      ov = v7_out; orr = r7_out; r = res7; s = st7;
    end else begin
      ov = v1_out; orr = r1_out; r = res1; s = st1;
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic op);
    if (sel) begin
      v7_in = v; a7 = a; b7 = b; op7 = op;
    end else begin
      v1_in = v; a1 = a; b1 = b; op1 = op;
    end
  endtask

  task automatic check_idle_reset(input bit sel, input string tag);
    logic ov, orr;
    logic [7:0] r;
    logic [3:0] s;
    get(sel, ov, orr, r, s);
    chk({tag, " o_valid"}, 32'(ov), 32'd0);
    chk({tag, " o_ready"}, 32'(orr), 32'd1);
    chk({tag, " o_result"}, 32'(r), 32'h00);
    chk({tag, " o_status"}, 32'(s), 32'h0);
  endtask

  // One full transaction: accept, wait for o_valid, check, then release.
  task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       input logic op, input logic [7:0] er, input logic [3:0] es,
                       input int elat, input string tag);
    logic ov, orr;
    logic [7:0] r;
    logic [3:0] s;
    int lat;
    get(sel, ov, orr, r, s);
    chk({tag, " ready_before"}, 32'(orr), 32'd1);
    drive(sel, 1'b1, a, b, op);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b, op);
    lat = 0;
    get(sel, ov, orr, r, s);
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      get(sel, ov, orr, r, s);
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " o_result"}, 32'(r), 32'(er));
    chk({tag, " o_status"}, 32'(s), 32'(es));
    $display("op step_w=%0d A=%02h B=%02h op=%0d -> result=%02h status=%04b latency=%0d",
             sel ? 7 : 1, a, b, op, r, s, lat);
    @(posedge clk); #1;
    get(sel, ov, orr, r, s);
    chk({tag, " valid_after"}, 32'(ov), 32'd0);
    chk({tag, " ready_after"}, 32'(orr), 32'd1);
    chk({tag, " result_hold"}, 32'(r), 32'(er));
  endtask

  initial begin
    logic ov, orr;
    logic [7:0] r;
    logic [3:0] s;
    int lat;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    r1_in = 1'b1;
    r7_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_reset(1'b0, "reset1");
    check_idle_reset(1'b1, "reset7");
    rst_n = 1'b1;

    // Basic arithmetic, STEP_W=1 (N=7).
    do_op(1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000, 7,  "add_5_3");
    do_op(1'b0, 8'h03, 8'h05, 1'b1, 8'h82, 4'b0100, 14, "sub_3_5_fix");
    do_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h00, 4'b1001, 7,  "ovf_pos");
    do_op(1'b0, 8'hFF, 8'h81, 1'b0, 8'h00, 4'b1001, 7,  "ovf_neg");
    do_op(1'b0, 8'h85, 8'h05, 1'b0, 8'h00, 4'b0010, 7,  "zero_m5_p5");
    do_op(1'b0, 8'h80, 8'h80, 1'b1, 8'h00, 4'b0010, 7,  "zero_negzero");
    do_op(1'b0, 8'h85, 8'h03, 1'b1, 8'h88, 4'b0100, 7,  "sub_m5_3");
    do_op(1'b0, 8'h80, 8'h03, 1'b0, 8'h03, 4'b0000, 14, "negzero_plus3");
    do_op(1'b0, 8'h40, 8'h3F, 1'b0, 8'h7F, 4'b0000, 7,  "add_max_noovf");

    // Backpressure: hold i_ready low in DONE while new operands are offered.
    r1_in = 1'b0;
    drive(1'b0, 1'b1, 8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
    lat = 0;
    get(1'b0, ov, orr, r, s);
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      get(1'b0, ov, orr, r, s);
    end
    chk("bp latency", 32'(lat), 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      get(1'b0, ov, orr, r, s);
      chk("bp o_valid", 32'(ov), 32'd1);
      chk("bp o_ready", 32'(orr), 32'd0);
      chk("bp o_result", 32'(r), 32'h08);
      chk("bp o_status", 32'(s), 32'h0);
    end
    $display("backpressure hold result=%02h status=%04b", r, s);
    r1_in = 1'b1;
    @(posedge clk); #1;
    get(1'b0, ov, orr, r, s);
    chk("bp release valid", 32'(ov), 32'd0);
    chk("bp release ready", 32'(orr), 32'd1);
    do_op(1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 4'b0000, 7, "bp_next");

    // Reset on the third CALC cycle aborts the operation.
    drive(1'b0, 1'b1, 8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h05, 8'h03, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_reset(1'b0, "midreset");
    $display("mid-operation reset applied");
    rst_n = 1'b1;
    do_op(1'b0, 8'h0A, 8'h84, 1'b1, 8'h0E, 4'b0000, 7, "after_reset");

    // STEP_W=7 (N=1): same arithmetic with single-step latency.
    do_op(1'b1, 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000, 1, "w7_add");
    do_op(1'b1, 8'h03, 8'h05, 1'b1, 8'h82, 4'b0100, 2, "w7_sub_fix");
    do_op(1'b1, 8'h7F, 8'h01, 1'b0, 8'h00, 4'b1001, 1, "w7_ovf");
    do_op(1'b1, 8'h0A, 8'h84, 1'b1, 8'h0E, 4'b0000, 1, "w7_after");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
